req_gnt_responder: RTL and testbench

Target-side responder for the single-wire req/gnt handshake used by the assertion IP benches. It watches an incoming req from an initiator and asserts gnt a fixed number of cycles later, unless a local hold blocks the grant. It holds gnt until req is released, flags over-long waits, and counts completed grants. It replaces the behavioural gnt driver so the req→gnt assertions can run against real RTL.

---
 rtl/req_gnt_responder_pkg.sv | 26 ++
 rtl/req_gnt_responder_wait_ctr.sv | 55 +++++
 rtl/req_gnt_responder.sv | 129 ++++++++++++
 tb/tb_req_gnt_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/req_gnt_responder_pkg.sv
// -----------------------------------------------------------------------------
// req_gnt_pkg
//   Shared definitions for the req/gnt target-side responder. The RTL, the
//   assertion IP and the bind module all import this package so that state_o
//   decodes identically wherever it is observed.
//
//   Contents:
//     state_t          2-bit FSM state encoding (IDLE/WAIT/GRANT/RELEASE)
//     DEF_GNT_DELAY    default cycles from first req sample to gnt rising
//     DEF_MAX_WAIT     default wait count at which wait_err pulses
//     DEF_CNT_W        default width of the completed-grant counter
// -----------------------------------------------------------------------------
package req_gnt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int DEF_GNT_DELAY = 3;
    localparam int DEF_MAX_WAIT  = 8;
    localparam int DEF_CNT_W     = 8;

endpackage : req_gnt_pkg

// File: rtl/req_gnt_responder_wait_ctr.sv
// -----------------------------------------------------------------------------
// req_gnt_wait_ctr
//   Saturating wait counter for the req/gnt responder. Counts cycles spent
//   waiting for a grant and reports when the grant delay has elapsed and
//   when the wait has become over-long.
//
//   Ports:
//     clk        in   clock, all logic on posedge
//     reset      in   asynchronous active-high reset
//     clr        in   synchronous clear to zero (wins over en)
//     en         in   advance the count by one, saturating at MAX_WAIT
//     delay_met  out  count >= GNT_DELAY-1 (grant may be issued this cycle)
//     at_max     out  high for the single cycle whose edge moves the count
//                     onto MAX_WAIT; cannot repeat until the next clear
// -----------------------------------------------------------------------------
module req_gnt_wait_ctr #(
    parameter int GNT_DELAY = 3,
    parameter int MAX_WAIT  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic delay_met,
    output logic at_max
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] DELAY_THR = CW'(GNT_DELAY - 1);
    localparam logic [CW-1:0] MAX_VAL   = CW'(MAX_WAIT);
    localparam logic [CW-1:0] PRE_MAX   = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX_VAL)) begin
            count <= count + CW'(1);
        end
    end

    // The threshold is compared against the pre-increment count: the first
    // WAIT cycle sees 0, so the grant edge lands GNT_DELAY edges after the
    // edge that first sampled req.
    assign delay_met = (count >= DELAY_THR);

    // Saturation guarantees the count passes MAX_WAIT-1 only once per clear,
    // which makes this a one-shot without extra state.
    assign at_max = en && !clr && (count == PRE_MAX);

endmodule : req_gnt_wait_ctr

// File: rtl/req_gnt_responder.sv
// -----------------------------------------------------------------------------
// req_gnt_responder
//   Target-side responder for the single-wire req/gnt handshake. Grants a
//   level request GNT_DELAY cycles after it is first seen (deferred while the
//   local resource is held), keeps gnt up until req drops, flags requests that
//   wait MAX_WAIT cycles, and counts completed grants.
//
//   Ports:
//     clk        in   clock, all logic on posedge
//     reset      in   asynchronous active-high reset
//     req        in   request from initiator, level, held until served
//     hold       in   local resource busy; blocks a new grant while high
//     gnt        out  registered grant
//     wait_err   out  registered one-cycle pulse on an over-long wait
//     grant_cnt  out  completed grants, wraps modulo 2^CNT_W
//     state_o    out  current FSM state (req_gnt_pkg::state_t encoding)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no request outstanding; wait counter held at zero
//   WAIT    | request seen, counting towards GNT_DELAY; hold defers grant
//   GRANT   | gnt high until req is released; hold ignored
//   RELEASE | mandatory one-cycle gap after a grant; req ignored
// -----------------------------------------------------------------------------
module req_gnt_responder
    import req_gnt_pkg::*;
#(
    parameter int GNT_DELAY = DEF_GNT_DELAY,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             hold,
    output logic             gnt,
    output logic             wait_err,
    output logic [CNT_W-1:0] grant_cnt,
    output logic [1:0]       state_o
);

    generate
        if (GNT_DELAY < 1) begin : g_bad_delay
            $error("req_gnt_responder: GNT_DELAY must be at least 1");
        end
        if (MAX_WAIT <= GNT_DELAY) begin : g_bad_max_wait
            $error("req_gnt_responder: MAX_WAIT must exceed GNT_DELAY");
        end
    endgenerate

    state_t state;

    logic ctr_clr;
    logic ctr_en;
    logic delay_met;
    logic at_max;
    logic grant_go;

    // Holding the counter cleared throughout IDLE gives the required
    // "cleared to 0 on entry to WAIT" without a dedicated transition strobe.
    assign ctr_clr = (state == IDLE);
    assign ctr_en  = (state == WAIT);

    req_gnt_wait_ctr #(
        .GNT_DELAY (GNT_DELAY),
        .MAX_WAIT  (MAX_WAIT)
    ) u_wait_ctr (
        .clk       (clk),
        .reset     (reset),
        .clr       (ctr_clr),
        .en        (ctr_en),
        .delay_met (delay_met),
        .at_max    (at_max)
    );

    assign grant_go = delay_met && !hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            wait_err  <= 1'b0;
            grant_cnt <= '0;
        end else begin
            wait_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    // Abandonment outranks a grant that becomes due on the
                    // same edge; the over-long pulse only fires when the
                    // request is still waiting after this edge.
                    if (!req) begin
                        state <= IDLE;
                    end else if (grant_go) begin
                        state <= GRANT;
                        gnt   <= 1'b1;
                    end else if (at_max) begin
                        wait_err <= 1'b1;
                    end
                end

                GRANT: begin
                    if (!req) begin
                        state     <= RELEASE;
                        gnt       <= 1'b0;
                        grant_cnt <= grant_cnt + CNT_W'(1);
                    end
                end

                RELEASE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    gnt   <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule : req_gnt_responder

// File: tb/tb_req_gnt_responder.sv
module tb_req_gnt_responder;

    localparam int GNT_DELAY = 3;
    localparam int MAX_WAIT  = 8;
    localparam int CNT_W     = 8;
    localparam int N_TXN     = 600;

    localparam int EV_ERR  = 0;
    localparam int EV_RISE = 1;
    localparam int EV_FALL = 2;

    logic             clk;
    logic             reset;
    logic             req;
    logic             hold;
    logic             gnt;
    logic             wait_err;
    logic [CNT_W-1:0] grant_cnt;
    logic [1:0]       state_o;

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;
    bit mon_en   = 1'b0;
    logic gnt_q  = 1'b0;

    typedef struct {
        int kind;
        int at;
        int cnt;
        int st;
    } ev_t;

    ev_t sb[$];

    req_gnt_responder #(
        .GNT_DELAY (GNT_DELAY),
        .MAX_WAIT  (MAX_WAIT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .hold      (hold),
        .gnt       (gnt),
        .wait_err  (wait_err),
        .grant_cnt (grant_cnt),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic push_ev(input int kind, input int at, input int cnt, input int st);
        ev_t ev;
        ev.kind = kind;
        ev.at   = at;
        ev.cnt  = cnt;
        ev.st   = st;
        sb.push_back(ev);
    endtask

    task automatic sb_check(input int kind);
        ev_t ev;
        chk($sformatf("sb_event_expected_kind%0d", kind), int'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        ev = sb.pop_front();
        chk("sb_kind", kind, ev.kind);
        chk($sformatf("sb_edge_kind%0d", ev.kind), edge_no, ev.at);
        chk($sformatf("sb_state_kind%0d", ev.kind), int'(state_o), ev.st);
        if (kind == EV_FALL) chk("sb_grant_cnt", int'(grant_cnt), ev.cnt);
    endtask

    // Monitor: every visible output event must match the oldest prediction.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (wait_err)       sb_check(EV_ERR);
            if (gnt && !gnt_q)  sb_check(EV_RISE);
            if (!gnt && gnt_q)  sb_check(EV_FALL);
            gnt_q = gnt;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Serve one request with hold low; returns grant latency or -1 on timeout.
    task automatic serve_once(output int lat);
        int e;
        bit found;
        @(negedge clk);
        req  = 1'b1;
        hold = 1'b0;
        e = edge_no + 1;
        lat = -1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (gnt) begin
                found = 1'b1;
                lat = edge_no - e;
            end
        end
    endtask

    initial begin
        int ready;
        int cnt_model;
        int lat;

        reset = 1'b1;
        req   = 1'b0;
        hold  = 1'b0;
        ready = 0;
        cnt_model = 0;

        #3;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_wait_err", int'(wait_err), 0);
        chk("rst_grant_cnt", int'(grant_cnt), 0);
        chk("rst_state", int'(state_o), 0);
        #17;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_gnt", int'(gnt), 0);
            chk("idle_wait_err", int'(wait_err), 0);
            chk("idle_grant_cnt", int'(grant_cnt), 0);
            chk("idle_state", int'(state_o), 0);
        end
        mon_en = 1'b1;

        // Random transactions. Each request is described by its gap, length
        // L and initial hold run H; outcomes follow from arithmetic on the
        // edge S where the responder first accepts the request.
        for (int n = 0; n < N_TXN; n++) begin
            int g, len, h, e, s, thr;
            g   = $urandom_range(1, 3);
            len = $urandom_range(1, 14);
            h   = ($urandom_range(0, 2) == 0) ? $urandom_range(4, 12) : 0;

            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                req  = 1'b0;
                hold = 1'($urandom_range(0, 1));
            end

            @(negedge clk);
            e = edge_no + 1;
            s = (e > ready) ? e : ready;
            thr = (h > GNT_DELAY) ? h : GNT_DELAY;

            if (len > MAX_WAIT && h > MAX_WAIT)
                push_ev(EV_ERR, s + MAX_WAIT, 0, 1);
            if (len > thr) begin
                push_ev(EV_RISE, s + thr, 0, 2);
                cnt_model = (cnt_model + 1) % (1 << CNT_W);
                push_ev(EV_FALL, s + len, cnt_model, 3);
                ready = s + len + 2;
            end else begin
                ready = s + len + 1;
            end

            for (int c = e; c < s + len; c++) begin
                if (c != e) @(negedge clk);
                req  = 1'b1;
                hold = (c < s) ? 1'($urandom_range(0, 1)) : 1'((c - s) < h);
            end
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req  = 1'b0;
            hold = 1'($urandom_range(0, 1));
        end
        chk("sb_drain", sb.size(), 0);
        chk("final_grant_cnt", int'(grant_cnt), cnt_model);
        chk("final_state", int'(state_o), 0);

        // Asynchronous reset in the middle of a grant.
        mon_en = 1'b0;
        serve_once(lat);
        chk("pre_reset_latency", lat, GNT_DELAY);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_gnt", int'(gnt), 0);
        chk("async_rst_grant_cnt", int'(grant_cnt), 0);
        chk("async_rst_state", int'(state_o), 0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_state", int'(state_o), 0);
        chk("post_rst_gnt", int'(gnt), 0);
        serve_once(lat);
        chk("post_rst_latency", lat, GNT_DELAY);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("post_rst_grant_cnt", int'(grant_cnt), 1);
        chk("post_rst_release_state", int'(state_o), 3);
        @(negedge clk);
        chk("post_rst_idle_state", int'(state_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_req_gnt_responder
